// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: turns PS/2 key_event records into an 8x8 cursor plus select/promo/move pulses.
// Define KEY_AUTOREPEAT_EN to auto-step the cursor while a direction key stays held.
module key_cmd_decoder #(
    parameter bit          CURSOR_WRAP   = 1'b1,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] key_event,
    input  logic        lock,
    output logic [2:0]  cursor_x,
    output logic [2:0]  cursor_y,
    output logic        select_pls,
    output logic        promo_pls,
    output logic        move_pls
);
    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    typedef struct packed {
        logic       known;
        logic       dir;
        logic       sel;
        logic       promo;
        logic [1:0] dx;
        logic [1:0] dy;
    } key_info_t;

    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] M1 = 2'b11;

    if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("key_cmd_decoder: REPEAT_DELAY and REPEAT_PERIOD must be nonzero");
    end

    // Key identity is {E0, code}; dx/dy are 2-bit two's complement steps.
    function automatic key_info_t key_decode(input logic [8:0] k);
        key_info_t i;
        i = '{known: 1'b1, dir: 1'b1, sel: 1'b0, promo: 1'b0, dx: 2'b00, dy: 2'b00};
        case (k)
            9'h015:                 begin i.dx = M1; i.dy = M1; end
            9'h024:                 begin i.dx = P1; i.dy = M1; end
            9'h01A:                 begin i.dx = M1; i.dy = P1; end
            9'h021:                 begin i.dx = P1; i.dy = P1; end
            9'h01D, 9'h175:         i.dy = M1;
            9'h01B, 9'h022, 9'h172: i.dy = P1;
            9'h01C, 9'h16B:         i.dx = M1;
            9'h023, 9'h174:         i.dx = P1;
            9'h029:                 begin i.dir = 1'b0; i.sel = 1'b1; end
            9'h034:                 begin i.dir = 1'b0; i.promo = 1'b1; end
            default:                i = '0;
        endcase
        return i;
    endfunction

    // Saturating mode keeps an axis pinned at 0/7 instead of wrapping.
    function automatic logic [2:0] step(input logic [2:0] c, input logic [1:0] d);
        logic [2:0] s;
        s = c + {d[1], d};
        if (!CURSOR_WRAP && ((d == M1 && c == 3'd0) || (d == P1 && c == 3'd7)))
            s = c;
        return s;
    endfunction

    state_t     state, state_nx;
    logic [8:0] held_code, held_code_nx;
    logic [2:0] x_nx, y_nx;
    logic       sel_nx, promo_nx, move_nx;
    logic [8:0] ev_key;
    key_info_t  ev_info, act_info;
    logic       accepted, act;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);
    logic [31:0] rpt_cnt, rpt_cnt_nx;
    key_info_t   held_info;
    assign held_info = key_decode(held_code);
`endif

    assign ev_key  = {key_event[9], key_event[7:0]};
    assign ev_info = key_decode(ev_key);

    always_comb begin
        state_nx     = state;
        held_code_nx = held_code;
        x_nx         = cursor_x;
        y_nx         = cursor_y;
        sel_nx       = 1'b0;
        promo_nx     = 1'b0;
        move_nx      = 1'b0;
        accepted     = 1'b0;
        act          = 1'b0;
        act_info     = ev_info;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_nx   = rpt_cnt;
`endif
        if (key_event[10] && ev_info.known) begin
            if (!key_event[8]) begin
                // A make of the already-held key is typematic and dropped.
                if (state == IDLE || ev_key != held_code) begin
                    held_code_nx = ev_key;
                    state_nx     = HELD;
                    accepted     = 1'b1;
                    act          = 1'b1;
                end
            end else if (state != IDLE && ev_key == held_code) begin
                state_nx = IDLE;
                accepted = 1'b1;
            end
        end
`ifdef KEY_AUTOREPEAT_EN
        if (accepted) begin
            rpt_cnt_nx = '0;
        end else if (state != IDLE && held_info.dir) begin
            if (rpt_cnt == ((state == HELD) ? DELAY_LAST : PERIOD_LAST)) begin
                rpt_cnt_nx = '0;
                state_nx   = REPEAT;
                act        = 1'b1;
                act_info   = held_info;
            end else begin
                rpt_cnt_nx = rpt_cnt + 32'd1;
            end
        end
`endif
        if (act && !lock) begin
            x_nx     = step(cursor_x, act_info.dx);
            y_nx     = step(cursor_y, act_info.dy);
            move_nx  = (x_nx != cursor_x) || (y_nx != cursor_y);
            sel_nx   = act_info.sel;
            promo_nx = act_info.promo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            held_code  <= '0;
            cursor_x   <= '0;
            cursor_y   <= '0;
            select_pls <= 1'b0;
            promo_pls  <= 1'b0;
            move_pls   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt    <= '0;
`endif
        end else begin
            state      <= state_nx;
            held_code  <= held_code_nx;
            cursor_x   <= x_nx;
            cursor_y   <= y_nx;
            select_pls <= sel_nx;
            promo_pls  <= promo_nx;
            move_pls   <= move_nx;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt    <= rpt_cnt_nx;
`endif
        end
    end
endmodule
